// File: rtl/gate_bist_pkg.sv
// Shared constants for the gate-select BIST: op encodings, golden truth table
// nibbles, FSM states and the vector-to-drive mapping.
package gate_bist_pkg;

    localparam int OP_AND  = 0;
    localparam int OP_OR   = 1;
    localparam int OP_NOT  = 2;
    localparam int OP_NAND = 3;
    localparam int OP_NOR  = 4;
    localparam int OP_XOR  = 5;

    localparam int NUM_VEC = 25;

    // Nibbles are indexed by {a,b}: bit3 = ab 11 ... bit0 = ab 00
    localparam logic [3:0] GOLD_AND  = 4'b1000;
    localparam logic [3:0] GOLD_OR   = 4'b1110;
    localparam logic [3:0] GOLD_NOT  = 4'b0011;
    localparam logic [3:0] GOLD_NAND = 4'b0111;
    localparam logic [3:0] GOLD_NOR  = 4'b0001;
    localparam logic [3:0] GOLD_XOR  = 4'b0110;

    // Vector 24 is the disable check, which must read back 0
    localparam logic [NUM_VEC-1:0] EXPECTED =
        {1'b0, GOLD_XOR, GOLD_NOR, GOLD_NAND, GOLD_NOT, GOLD_OR, GOLD_AND};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic       enable;
        logic [2:0] op;
        logic       a;
        logic       b;
    } drive_t;

    localparam drive_t DRIVE_IDLE = '0;

    function automatic drive_t vec_drive(input logic [4:0] k);
        drive_t d;
        if (k == 5'(NUM_VEC - 1)) begin
            d.enable = 1'b0;
            d.op     = 3'b000;
            d.a      = 1'b1;
            d.b      = 1'b1;
        end else begin
            d.enable = 1'b1;
            d.op     = k[4:2];
            d.a      = k[1];
            d.b      = k[0];
        end
        return d;
    endfunction

endpackage

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: sweeps all 25 gate-unit vectors, samples gate_out after a
// settle interval and accumulates a per-vector result and mismatch map.
module gate_bist_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        gate_out,
    output logic        data1,
    output logic        data2,
    output logic        Enable,
    output logic [2:0]  op_cntrl,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [24:0] fail_mask,
    output logic [24:0] result_vec
);
    import gate_bist_pkg::*;

    state_t      state_q, state_d;
    logic [4:0]  vec_q, vec_d;
    logic [3:0]  cnt_q, cnt_d;
    drive_t      drive_q, drive_d;
    logic        busy_d, done_d, pass_d;
    logic [24:0] fail_d, res_d;
    logic        sample_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            drive_q    <= DRIVE_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_mask  <= '0;
            result_vec <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            drive_q    <= drive_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            fail_mask  <= fail_d;
            result_vec <= res_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        drive_d    = drive_q;
        busy_d     = busy;
        done_d     = done;
        pass_d     = pass;
        fail_d     = fail_mask;
        res_d      = result_vec;
        sample_bad = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    cnt_d   = '0;
                    fail_d  = '0;
                    res_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    drive_d = vec_drive(5'd0);
                end
            end
            RUN: begin
                if (cnt_q == 4'(SETTLE_CYCLES)) begin
                    sample_bad    = (gate_out != EXPECTED[vec_q]);
                    res_d[vec_q]  = gate_out;
                    fail_d[vec_q] = sample_bad;
                    cnt_d         = '0;
                    if (vec_q == 5'(NUM_VEC - 1)) begin
                        // pass must include the bit written on this same edge
                        state_d = DONE;
                        vec_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_d == '0);
                        drive_d = DRIVE_IDLE;
                    end else begin
                        vec_d   = vec_q + 5'd1;
                        drive_d = vec_drive(vec_q + 5'd1);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data1    = drive_q.a;
    assign data2    = drive_q.b;
    assign Enable   = drive_q.enable;
    assign op_cntrl = drive_q.op;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: behavioural gate unit with injectable faults,
// table of sweep outcomes, and hand sequences for retrigger and mid-sweep reset.
module tb_gate_bist_ctrl;
    import gate_bist_pkg::*;

    localparam logic [24:0] GOLD = 25'h06173E8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a_n, rst_b_n, start_a, start_b;
    logic        d1_a, d2_a, en_a, busy_a, done_a, pass_a, gate_a;
    logic        d1_b, d2_b, en_b, busy_b, done_b, pass_b, gate_b;
    logic [2:0]  op_a, op_b;
    logic [24:0] fm_a, rv_a, fm_b, rv_b;

    int          mode_a;
    logic [24:0] flip_a;
    int          passed = 0;
    int          total  = 0;
    int          op_bad = 0;

    // Gate unit: correct truth table, then optional fault
    // mode 0 ok, 1 stuck-at-0, 2 stuck-at-1, 3 NOR answered for OR, 4 per-vector flips
    function automatic logic gate_fn(input int mode, input logic [24:0] flip, input logic en,
                                     input logic [2:0] op, input logic a, input logic b);
        logic t;
        int   k;
        t = 1'b0;
        k = 24;
        if (en) begin
            k = int'({op, a, b});
            case (int'(op))
                OP_AND:  t = a & b;
                OP_OR:   t = (mode == 3) ? ~(a | b) : (a | b);
                OP_NOT:  t = ~a;
                OP_NAND: t = ~(a & b);
                OP_NOR:  t = ~(a | b);
                OP_XOR:  t = a ^ b;
                default: t = 1'b0;
            endcase
        end
        if (mode == 1) return 1'b0;
        if (mode == 2) return 1'b1;
        if (mode == 4 && k < 25) return t ^ flip[k];
        return t;
    endfunction

    function automatic logic [5:0] enc(input int k);
        logic [4:0] kk;
        kk = 5'(k);
        if (k < 24) return {1'b1, kk[4:2], kk[1:0]};
        return 6'b000011;
    endfunction

    assign gate_a = gate_fn(mode_a, flip_a, en_a, op_a, d1_a, d2_a);
    assign gate_b = gate_fn(0, 25'd0, en_b, op_b, d1_b, d2_b);

    gate_bist_ctrl #(.SETTLE_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .start(start_a), .gate_out(gate_a),
        .data1(d1_a), .data2(d2_a), .Enable(en_a), .op_cntrl(op_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_mask(fm_a), .result_vec(rv_a)
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .start(start_b), .gate_out(gate_b),
        .data1(d1_b), .data2(d2_b), .Enable(en_b), .op_cntrl(op_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_mask(fm_b), .result_vec(rv_b)
    );

    always @(negedge clk) begin
        if (op_a[2:1] == 2'b11 || op_b[2:1] == 2'b11) op_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic run_a(input string name, input int mode, input logic [24:0] flip,
                         input logic ep, input logic [24:0] ef, input logic [24:0] er);
        int n;
        int bad;
        mode_a  = mode;
        flip_a  = flip;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        n   = 0;
        bad = 0;
        while (!done_a && n < 200) begin
            if ({en_a, op_a, d1_a, d2_a} !== enc(n / 2) || busy_a !== 1'b1) bad++;
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drive_seq"}, bad, 0);
        check({name, "_latency"}, n, 50);
        check({name, "_pass"}, pass_a, ep);
        check({name, "_fail_mask"}, fm_a, ef);
        check({name, "_result_vec"}, rv_a, er);
        check({name, "_busy_off"}, busy_a, 0);
        check({name, "_drive_idle"}, {en_a, op_a, d1_a, d2_a}, 0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_done_sticky"}, {done_a, pass_a}, {1'b1, ep});
    endtask

    typedef struct {
        int          mode;
        logic [24:0] flip;
        logic        exp_pass;
        logic [24:0] exp_fail;
        logic [24:0] exp_res;
    } row_t;

    row_t tbl[8];
    int   n_b, bad_b;

    initial begin
        tbl[0] = '{0, 25'd0, 1'b1, 25'd0, GOLD};
        tbl[1] = '{1, 25'd0, 1'b0, GOLD, 25'd0};
        tbl[2] = '{2, 25'd0, 1'b0, 25'h19E8C17, 25'h1FFFFFF};
        tbl[3] = '{3, 25'd0, 1'b0, 25'h00000F0, GOLD ^ 25'h00000F0};
        tbl[4] = '{4, 25'h1000000, 1'b0, 25'h1000000, GOLD | 25'h1000000};
        for (int i = 5; i < 8; i++) begin
            logic [24:0] f;
            f = 25'($urandom);
            if (i == 7) f = f & 25'($urandom) & 25'($urandom);
            tbl[i] = '{4, f, (f == 25'd0), f, GOLD ^ f};
        end

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        mode_a  = 0;
        flip_a  = '0;
        #12;
        check("rst_ctrl", {busy_a, done_a, pass_a}, 0);
        check("rst_fail_mask", fm_a, 0);
        check("rst_result_vec", rv_a, 0);
        check("rst_drive", {en_a, op_a, d1_a, d2_a}, 0);
        @(negedge clk);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst", {busy_a, done_a, busy_b, done_b}, 0);

        for (int i = 0; i < 8; i++)
            run_a($sformatf("row%0d", i), tbl[i].mode, tbl[i].flip,
                  tbl[i].exp_pass, tbl[i].exp_fail, tbl[i].exp_res);

        // SETTLE_CYCLES=3 with a retrigger 20 cycles into the sweep
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n_b   = 0;
        bad_b = 0;
        while (!done_b && n_b < 400) begin
            if ({en_b, op_b, d1_b, d2_b} !== enc(n_b / 4) || busy_b !== 1'b1) bad_b++;
            start_b = (n_b == 20);
            @(posedge clk); #1;
            n_b++;
        end
        start_b = 1'b0;
        check("b_drive_seq", bad_b, 0);
        check("b_latency", n_b, 100);
        check("b_pass", pass_b, 1);
        check("b_fail_mask", fm_b, 0);
        check("b_result_vec", rv_b, GOLD);

        // Reset 30 cycles into a sweep with a fault active, then a clean rerun
        mode_a  = 2;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst_a_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {busy_a, done_a, pass_a}, 0);
        check("mid_rst_fail_mask", fm_a, 0);
        check("mid_rst_result_vec", rv_a, 0);
        check("mid_rst_drive", {en_a, op_a, d1_a, d2_a}, 0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_a_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", {busy_a, done_a, en_a, op_a, d1_a, d2_a}, 0);
        run_a("post_rst", 0, 25'd0, 1'b1, 25'd0, GOLD);

        check("op_110_111_never", op_bad, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
